// File: rtl/bus_bridge_demux_pkg.sv
// bus_bridge_pkg: shared types and constants for the data-bus bridge family
// Contents: FSM state enum, slave index constants, default error fill word.
package bus_bridge_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;
    localparam int NUM_SLV = 4;
    typedef logic [1:0] slv_idx_t;
    localparam slv_idx_t SLV_DM    = 2'd0;
    localparam slv_idx_t SLV_TIMER = 2'd1;
    localparam slv_idx_t SLV_IO    = 2'd2;
    localparam slv_idx_t SLV_SPARE = 2'd3;
    localparam logic [31:0] DEFAULT_FILL = 32'h2333_3333;
endpackage

// File: rtl/bus_bridge_demux_if.sv
// bus_bridge_demux_if: CPU-side and slave-side signals of the data-bus bridge
// CPU side : m_req, m_we, m_addr, m_wdata, m_be -> bridge; m_ready, m_rdata, m_err <- bridge
// Slave side: s_req (one-hot), s_we, s_addr, s_wdata, s_be <- bridge; s_ack, s_rdata -> bridge
// Modport slave is the bridge's view; modport master is the CPU plus slaves around it.
interface bus_bridge_demux_if;
    import bus_bridge_pkg::*;
    logic                   m_req;
    logic                   m_we;
    logic [31:0]            m_addr;
    logic [31:0]            m_wdata;
    logic [3:0]             m_be;
    logic                   m_ready;
    logic [31:0]            m_rdata;
    logic                   m_err;
    logic [NUM_SLV-1:0]     s_req;
    logic                   s_we;
    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_be;
    logic [NUM_SLV-1:0]     s_ack;
    logic [32*NUM_SLV-1:0]  s_rdata;
    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be, s_ack, s_rdata,
        output m_ready, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, s_be
    );
    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be, s_ack, s_rdata,
        input  m_ready, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, s_be
    );
endinterface

// File: rtl/bus_bridge_demux_decode.sv
// bus_bridge_decode: combinational address decode to {mapped, slave index}
// Ports: i_addr_hi = address bits [31:SEL_LSB]; o_mapped = no bits set above the
// select field; o_idx = 2-bit slave select field.
module bus_bridge_decode
    import bus_bridge_pkg::*;
#(
    parameter int SEL_LSB = 12
) (
    input  logic [31:SEL_LSB] i_addr_hi,
    output logic              o_mapped,
    output slv_idx_t          o_idx
);
    assign o_mapped = ~|i_addr_hi[31:SEL_LSB+2];
    assign o_idx    = i_addr_hi[SEL_LSB+1:SEL_LSB];
endmodule

// File: rtl/bus_bridge_demux.sv
// bus_bridge_demux: single-outstanding bridge steering one CPU data access to one of four slaves
// Ports: clk, rst_n (async active-low); bus = bus_bridge_demux_if.slave carrying the CPU
// req/ack side (m_*) and the one-hot slave request side (s_*).
// Build option: BUS_BRIDGE_TIMEOUT_EN adds an 8-bit WAIT counter that aborts a dead slave
// with m_err and the default fill word after TIMEOUT+1 WAIT cycles.
module bus_bridge_demux
    import bus_bridge_pkg::*;
#(
    parameter int          SEL_LSB       = 12,
    parameter int          TIMEOUT       = 255,
    parameter logic [31:0] DEFAULT_RDATA = DEFAULT_FILL
) (
    input logic               clk,
    input logic               rst_n,
    bus_bridge_demux_if.slave bus
);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]         r_state;
    slv_idx_t           r_idx;
    logic [NUM_SLV-1:0] r_s_req;
    logic               r_m_ready;
    logic               r_m_err;
    logic [31:0]        r_m_rdata;
    logic               r_s_we;
    logic [31:0]        r_s_addr;
    logic [31:0]        r_s_wdata;
    logic [3:0]         r_s_be;
    logic               w_mapped;
    slv_idx_t           w_idx;
    logic               w_ack;

    bus_bridge_decode #(.SEL_LSB(SEL_LSB)) u_decode (
        .i_addr_hi (bus.m_addr[31:SEL_LSB]),
        .o_mapped  (w_mapped),
        .o_idx     (w_idx)
    );

    // only the selected slave's ack counts; strays from the others are ignored
    assign w_ack = bus.s_ack[r_idx];

`ifdef BUS_BRIDGE_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       w_expired;
    assign w_expired = r_cnt == 8'(TIMEOUT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_s_req   <= '0;
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rdata <= '0;
            r_s_we    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_be    <= '0;
`ifdef BUS_BRIDGE_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (bus.m_req) begin
                    if (w_mapped) begin
                        r_idx     <= w_idx;
                        r_s_req   <= NUM_SLV'(1) << w_idx;
                        r_s_we    <= bus.m_we;
                        r_s_addr  <= bus.m_addr;
                        r_s_wdata <= bus.m_wdata;
                        r_s_be    <= bus.m_be;
`ifdef BUS_BRIDGE_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                        r_state   <= S_WAIT;
                    end else begin
                        r_m_err   <= 1'b1;
                        r_m_rdata <= DEFAULT_RDATA;
                        r_m_ready <= 1'b1;
                        r_state   <= S_RESP;
                    end
                end
                S_WAIT: if (w_ack) begin
                    r_s_req   <= '0;
                    if (!r_s_we) r_m_rdata <= bus.s_rdata[r_idx*32 +: 32];
                    r_m_err   <= 1'b0;
                    r_m_ready <= 1'b1;
                    r_state   <= S_RESP;
                end
`ifdef BUS_BRIDGE_TIMEOUT_EN
                else if (w_expired) begin
                    r_s_req   <= '0;
                    r_m_err   <= 1'b1;
                    r_m_rdata <= DEFAULT_RDATA;
                    r_m_ready <= 1'b1;
                    r_state   <= S_RESP;
                end else r_cnt <= r_cnt + 8'd1;
`endif
                // RESP (and the unused encoding) returns to IDLE after the one-cycle pulse
                default: begin
                    r_m_ready <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_ready = r_m_ready;
    assign bus.m_rdata = r_m_rdata;
    assign bus.m_err   = r_m_err;
    assign bus.s_req   = r_s_req;
    assign bus.s_we    = r_s_we;
    assign bus.s_addr  = r_s_addr;
    assign bus.s_wdata = r_s_wdata;
    assign bus.s_be    = r_s_be;
endmodule

// File: tb/tb_bus_bridge_demux.sv
// tb_bus_bridge_demux: scoreboard bench for bus_bridge_demux with a randomized slave model
module tb_bus_bridge_demux;
    localparam int          SEL_LSB = 12;
    localparam int          TIMEOUT = 6;
    localparam logic [31:0] DEF     = 32'h2333_3333;
`ifdef BUS_BRIDGE_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    typedef struct {
        int          rdy_cyc;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  sreq;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q[$];
    logic [31:0] last_rdata = '0;
    int          cur_delay = 0;
    logic [31:0] cur_rdata = '0;
    bit          abort = 1'b0;

    bus_bridge_demux_if bus();

    bus_bridge_demux #(.SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT), .DEFAULT_RDATA(DEF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // reference model: outcome of one access from the decode/handshake rules
    function automatic exp_t predict(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                     input logic [3:0] be, input int delay, input logic [31:0] rdata,
                                     input int start);
        exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
        if ((addr >> (SEL_LSB + 2)) != 0) begin
            e.err = 1'b1; e.rdata = DEF; e.sreq = 4'b0; e.rdy_cyc = start + 1;
        end else begin
            e.sreq = 4'(1 << ((addr >> SEL_LSB) & 3));
            if (TEN && delay > TIMEOUT) begin
                e.err = 1'b1; e.rdata = DEF; e.rdy_cyc = start + TIMEOUT + 2;
            end else begin
                e.err = 1'b0; e.rdata = we ? last_rdata : rdata; e.rdy_cyc = start + 2 + delay;
            end
        end
        last_rdata = e.rdata;
        return e;
    endfunction

    // slave model: the selected slave acks after cur_delay wait cycles; others babble
    initial begin
        int wcnt;
        wcnt = 0;
        bus.s_ack = '0;
        bus.s_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.s_req != 0) begin
                bus.s_ack = (wcnt == cur_delay ? bus.s_req : 4'b0) | (4'($urandom) & ~bus.s_req);
                for (int i = 0; i < 4; i++) bus.s_rdata[32*i +: 32] = bus.s_req[i] ? cur_rdata : $urandom;
                wcnt++;
            end else begin
                wcnt = 0;
                bus.s_ack = 4'($urandom);
            end
        end
    end

    // monitor: checks slave-side requests and pops expectations on every m_ready
    initial begin
        logic [3:0] prev_sreq;
        exp_t e;
        prev_sreq = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                prev_sreq = '0;
                continue;
            end
            if (bus.s_req != 0) begin
                if (q.size() == 0) fail("s_req_without_txn");
                else if (prev_sreq == 0) begin
                    chk("s_req", 32'(bus.s_req), 32'(q[0].sreq));
                    if (q[0].sreq != 0) begin
                        chk("s_we", 32'(bus.s_we), 32'(q[0].we));
                        chk("s_addr", bus.s_addr, q[0].addr);
                        chk("s_wdata", bus.s_wdata, q[0].wdata);
                        chk("s_be", 32'(bus.s_be), 32'(q[0].be));
                    end
                end else chk("s_req_hold", 32'(bus.s_req), 32'(q[0].sreq));
            end
            if (bus.m_ready) begin
                if (q.size() == 0) fail("m_ready_without_txn");
                else begin
                    e = q.pop_front();
                    chk("ready_cycle", cyc, e.rdy_cyc);
                    chk("m_rdata", bus.m_rdata, e.rdata);
                    chk("m_err", 32'(bus.m_err), 32'(e.err));
                    chk("s_req_in_resp", 32'(bus.s_req), 32'h0);
                end
            end
            prev_sreq = bus.s_req;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_s_req"}, 32'(bus.s_req), 32'h0);
        chk({tag, "_m_ready"}, 32'(bus.m_ready), 32'h0);
        chk({tag, "_m_err"}, 32'(bus.m_err), 32'h0);
        chk({tag, "_m_rdata"}, bus.m_rdata, 32'h0);
        chk({tag, "_s_we"}, 32'(bus.s_we), 32'h0);
        chk({tag, "_s_addr"}, bus.s_addr, 32'h0);
        chk({tag, "_s_wdata"}, bus.s_wdata, 32'h0);
        chk({tag, "_s_be"}, 32'(bus.s_be), 32'h0);
    endtask

    // one access; keep=1 leaves m_req high so the next call starts back-to-back
    task automatic run(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] be, input int delay, input logic [31:0] rdata, input bit keep);
        int start;
        bit done;
        if (abort) return;
        start = bus.m_req ? cyc + 1 : cyc;
        cur_delay = delay;
        cur_rdata = rdata;
        bus.m_addr = addr;
        bus.m_we = we;
        bus.m_wdata = wdata;
        bus.m_be = be;
        bus.m_req = 1'b1;
        q.push_back(predict(addr, we, wdata, be, delay, rdata, start));
        done = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            @(negedge clk);
            done = bus.m_ready;
        end
        if (!done) begin
            fail("m_ready_never_arrived");
            abort = 1'b1;
            bus.m_req = 1'b0;
            return;
        end
        if (!keep) begin
            bus.m_req = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic reset_in_wait();
        exp_t e;
        if (abort) return;
        cur_delay = 1000;
        bus.m_addr = 32'h0000_2004;
        bus.m_we = 1'b0;
        bus.m_be = 4'hf;
        bus.m_req = 1'b1;
        e = predict(32'h0000_2004, 1'b0, bus.m_wdata, 4'hf, 1000, 32'h0, cyc);
        q.push_back(e);
        repeat (3) @(negedge clk);
        chk("s_req_before_reset", 32'(bus.s_req), 32'h4);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("s_req_async_drop", 32'(bus.s_req), 32'h0);
        bus.m_req = 1'b0;
        last_rdata = '0;
        repeat (2) @(negedge clk);
        check_reset("midrst");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        bus.m_req = 1'b0;
        bus.m_we = 1'b0;
        bus.m_addr = '0;
        bus.m_wdata = '0;
        bus.m_be = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);
        run(32'h0000_1004, 1'b0, 32'h0, 4'hf, 0, 32'hCAFE_F00D, 1'b0);
        run(32'h0000_3000, 1'b1, 32'h1234_5678, 4'b0011, 5, 32'h0BAD_0BAD, 1'b0);
        run(32'h0001_0000, 1'b0, 32'h0, 4'hf, 0, 32'h1111_1111, 1'b0);
`ifdef BUS_BRIDGE_TIMEOUT_EN
        run(32'h0000_2000, 1'b0, 32'h0, 4'hf, 1000, 32'h4444_4444, 1'b0);
        run(32'h0000_2008, 1'b0, 32'h0, 4'hf, TIMEOUT, 32'h5A5A_5A5A, 1'b0);
`endif
        run(32'h0000_2010, 1'b0, 32'h0, 4'hf, 3, 32'hA5A5_0001, 1'b1);
        run(32'h0000_0020, 1'b0, 32'h0, 4'hf, 1, 32'hA5A5_0002, 1'b0);
        reset_in_wait();
        run(32'h0000_1008, 1'b0, 32'h0, 4'hf, 2, 32'h7777_0001, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) a = $urandom | (32'h1 << $urandom_range(14, 31));
            else a = {18'h0, 2'($urandom), 12'($urandom)};
            run(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, TIMEOUT + 2), $urandom,
                (i < 39) && ($urandom_range(0, 2) == 0));
        end
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
